facto_master: RTL and testbench
===============================

Name: facto_master

Overview:
- Bus master that sits directly upstream of the BUS/ram/FactoCore subsystem and drives its m_* master port.
- On a start pulse it runs a factorial job: programs the core, waits for its interrupt, reads the 128-bit result, writes it to RAM, then clears the core.
- It also exposes the result and status to the surrounding logic.

Parameters:
- FC_BASE, 16'h7000, base address of the factorial core register window
- RAM_BASE, 16'h0000, base address of the RAM window
- OFF_START, 16'h0000, core opstart register offset
- OFF_CLEAR, 16'h0008, core opclear register offset
- OFF_INTEN, 16'h0010, core interrupt-enable register offset
- OFF_OPND, 16'h0018, core operand register offset
- OFF_RESH, 16'h0020, core result-high register offset
- OFF_RESL, 16'h0028, core result-low register offset
- TIMEOUT, 4096, max cycles to wait for the interrupt before aborting

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request; ignored unless idle
- operand  in  64  N for N!; captured on an accepted start
- ram_idx  in  8  RAM word index for result-high; result-low goes to ram_idx+1 (mod 256); captured on start
- m_grant  in  1  bus grant from the arbiter
- m_din  in  64  bus read data
- interrupt  in  1  core completion interrupt, level
- m_req  out  1  bus request
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  16  bus address
- m_dout  out  64  bus write data
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- timeout  out  1  sticky error flag, cleared by the next accepted start
- result_h  out  64  last result high word
- result_l  out  64  last result low word

Behaviour:
- Reset: every output is 0 and the FSM is IDLE; captured operand and ram_idx are 0. Reset mid-job aborts immediately; the core is not cleared.
- Bus rules:
  - m_req rises when the job starts and stays high until RELEASE.
  - Transfers are issued only while m_grant=1. If m_grant=0, the FSM stalls in its current state with m_addr, m_wr and m_dout held stable.
  - Write: one cycle with m_wr=1, address and data valid, under grant.
  - Read: one cycle with m_wr=0 and address valid; m_din is sampled on the next cycle, which is a CAP state that holds the address.
- FSM states and actions, in order:
  - IDLE: accept start when start=1; capture inputs, busy<=1, timeout<=0 → REQ.
  - REQ: m_req=1; wait for m_grant → W_INTEN.
  - W_INTEN: write 1 to FC_BASE+OFF_INTEN.
  - W_OPND: write operand to FC_BASE+OFF_OPND.
  - W_START: write 1 to FC_BASE+OFF_START.
  - WAIT_INT: m_req stays high with no transfer (m_wr=0, address held); a 13-bit counter increments each cycle.
    - interrupt=1 → R_RESH.
    - Counter reaches TIMEOUT-1 without an interrupt → timeout<=1 → W_CLEAR.
  - R_RESH, CAP_H: read FC_BASE+OFF_RESH; result_h<=m_din.
  - R_RESL, CAP_L: read FC_BASE+OFF_RESL; result_l<=m_din.
  - W_RAMH: write result_h to RAM_BASE + {ram_idx,3'b000}.
  - W_RAML: write result_l to RAM_BASE + {ram_idx+1,3'b000}.
  - W_CLEAR: write 1 then 0 to FC_BASE+OFF_CLEAR, as two write cycles.
  - RELEASE: m_req=0 → IDLE, with done=1 for that one cycle and busy<=0.
- Latency with grant always high: start to done = 13 cycles + interrupt wait.
- Simultaneous events:
  - start while busy is ignored.
  - interrupt and timeout reached in the same cycle: the interrupt wins.
  - interrupt already high on entry to WAIT_INT leaves after 1 cycle.
- result_h/result_l keep their old values on a timeout job.
- Address arithmetic is 16-bit, with wrap-around and no carry.

Test Plan:
1. Reset, then operand=5, ram_idx=8'h02, start; grant tied high; model core raises interrupt 10 cycles after the start write → result_h=0, result_l=120. RAM word 2=0 and word 3=120. done pulses once; busy is low afterwards.
2. operand=20, ram_idx=8'hFF → RAM word FF=high, word 00=20! low (2432902008176640000); wrap is verified.
3. m_grant deasserted for 5 cycles during W_OPND → m_addr=FC_BASE+18 and data held stable; the transfer completes after grant returns; result is still correct.
4. No interrupt is raised → timeout=1 after TIMEOUT cycles in WAIT_INT; the clear writes occur; result_h/l are unchanged; done pulses. The next start clears timeout.
5. start pulsed again during WAIT_INT → ignored; a single done pulse only.
6. reset_n asserted low during R_RESL → all outputs go to 0 immediately; a subsequent start runs a clean job.

Source files
------------

// File: rtl/facto_master_if.sv
// Bus port bundle between facto_master and the BUS/ram/FactoCore subsystem.
// Combinational wiring only; no latency of its own.
// Backpressure is carried by m_grant: the master holds its request until granted.
interface facto_master_if;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );
endinterface

// File: rtl/facto_master.sv
// Factorial job master: programs FactoCore, waits for its interrupt, moves the 128-bit result to RAM, clears the core.
// Latency: start to done = 13 cycles + interrupt wait, with grant held high.
// Backpressure: while m_grant is low the FSM stalls in place with address, direction and write data held stable.
module facto_master #(
  parameter logic [15:0] FC_BASE   = 16'h7000,
  parameter logic [15:0] RAM_BASE  = 16'h0000,
  parameter logic [15:0] OFF_START = 16'h0000,
  parameter logic [15:0] OFF_CLEAR = 16'h0008,
  parameter logic [15:0] OFF_INTEN = 16'h0010,
  parameter logic [15:0] OFF_OPND  = 16'h0018,
  parameter logic [15:0] OFF_RESH  = 16'h0020,
  parameter logic [15:0] OFF_RESL  = 16'h0028,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  facto_master_if.master        bus,
  input  logic                  start,
  input  logic [63:0]           operand,
  input  logic [7:0]            ram_idx,
  input  logic                  interrupt,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [63:0]           result_h,
  output logic [63:0]           result_l
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_W_INTEN, S_W_OPND, S_W_START, S_WAIT_INT,
    S_R_RESH, S_CAP_H, S_R_RESL, S_CAP_L, S_W_RAMH, S_W_RAML,
    S_W_CLR1, S_W_CLR0, S_RELEASE
  } state_t;

  // Last cycle of the interrupt wait window (counter starts at 0 on entry).
  localparam logic [12:0] TO_LAST = 13'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [12:0] r_wait_cnt;
  logic [63:0] r_operand;
  logic [7:0]  r_ram_idx;
  logic        r_busy;
  logic        r_timeout;
  logic [63:0] r_result_h;
  logic [63:0] r_result_l;

  logic        w_accept;
  logic        w_wait_expired;
  logic [7:0]  w_idx_l;
  logic [15:0] w_ramh_addr;
  logic [15:0] w_raml_addr;
  logic        w_req;
  logic        w_wr;
  logic [15:0] w_addr;
  logic [63:0] w_dout;

  assign w_accept       = (r_state == S_IDLE) && start;
  assign w_wait_expired = (r_state == S_WAIT_INT) && !interrupt && (r_wait_cnt == TO_LAST);
  // Low word lands in the next RAM word; the 8-bit index wraps 0xFF -> 0x00.
  assign w_idx_l        = r_ram_idx + 8'd1;
  assign w_ramh_addr    = RAM_BASE + {5'b00000, r_ram_idx, 3'b000};
  assign w_raml_addr    = RAM_BASE + {5'b00000, w_idx_l, 3'b000};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: bus states advance only under grant; interrupt beats timeout in WAIT_INT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start)       w_next = S_REQ;
      S_REQ:      if (bus.m_grant) w_next = S_W_INTEN;
      S_W_INTEN:  if (bus.m_grant) w_next = S_W_OPND;
      S_W_OPND:   if (bus.m_grant) w_next = S_W_START;
      S_W_START:  if (bus.m_grant) w_next = S_WAIT_INT;
      S_WAIT_INT: begin
        if (interrupt)                  w_next = S_R_RESH;
        else if (r_wait_cnt == TO_LAST) w_next = S_W_CLR1;
      end
      S_R_RESH:   if (bus.m_grant) w_next = S_CAP_H;
      S_CAP_H:                     w_next = S_R_RESL;
      S_R_RESL:   if (bus.m_grant) w_next = S_CAP_L;
      S_CAP_L:                     w_next = S_W_RAMH;
      S_W_RAMH:   if (bus.m_grant) w_next = S_W_RAML;
      S_W_RAML:   if (bus.m_grant) w_next = S_W_CLR1;
      S_W_CLR1:   if (bus.m_grant) w_next = S_W_CLR0;
      S_W_CLR0:   if (bus.m_grant) w_next = S_RELEASE;
      S_RELEASE:                   w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  // Bus outputs per state; WAIT_INT and CAP states keep the previous address on the bus.
  always_comb begin
    w_req  = 1'b1;
    w_wr   = 1'b0;
    w_addr = 16'h0000;
    w_dout = 64'd0;
    case (r_state)
      S_IDLE:     w_req = 1'b0;
      S_REQ:      ;
      S_W_INTEN:  begin w_wr = 1'b1; w_addr = FC_BASE + OFF_INTEN; w_dout = 64'd1;     end
      S_W_OPND:   begin w_wr = 1'b1; w_addr = FC_BASE + OFF_OPND;  w_dout = r_operand; end
      S_W_START:  begin w_wr = 1'b1; w_addr = FC_BASE + OFF_START; w_dout = 64'd1;     end
      S_WAIT_INT: begin              w_addr = FC_BASE + OFF_START; w_dout = 64'd1;     end
      S_R_RESH,
      S_CAP_H:                       w_addr = FC_BASE + OFF_RESH;
      S_R_RESL,
      S_CAP_L:                       w_addr = FC_BASE + OFF_RESL;
      S_W_RAMH:   begin w_wr = 1'b1; w_addr = w_ramh_addr; w_dout = r_result_h; end
      S_W_RAML:   begin w_wr = 1'b1; w_addr = w_raml_addr; w_dout = r_result_l; end
      S_W_CLR1:   begin w_wr = 1'b1; w_addr = FC_BASE + OFF_CLEAR; w_dout = 64'd1; end
      S_W_CLR0:   begin w_wr = 1'b1; w_addr = FC_BASE + OFF_CLEAR; w_dout = 64'd0; end
      S_RELEASE:  begin w_req = 1'b0; w_addr = FC_BASE + OFF_CLEAR;                end
      default:    w_req = 1'b0;
    endcase
  end

  // Job context, status flags, captured results and the interrupt wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_operand  <= 64'd0;
      r_ram_idx  <= 8'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_result_h <= 64'd0;
      r_result_l <= 64'd0;
      r_wait_cnt <= 13'd0;
    end else begin
      if (w_accept) begin
        r_operand <= operand;
        r_ram_idx <= ram_idx;
        r_busy    <= 1'b1;
        r_timeout <= 1'b0;
      end
      if (r_state == S_RELEASE) r_busy <= 1'b0;
      if (w_wait_expired)       r_timeout <= 1'b1;
      if (r_state == S_CAP_H)   r_result_h <= bus.m_din;
      if (r_state == S_CAP_L)   r_result_l <= bus.m_din;
      if (r_state == S_WAIT_INT) r_wait_cnt <= r_wait_cnt + 13'd1;
      else                       r_wait_cnt <= 13'd0;
    end
  end

  assign bus.m_req  = w_req;
  assign bus.m_wr   = w_wr;
  assign bus.m_addr = w_addr;
  assign bus.m_dout = w_dout;
  assign busy       = r_busy;
  assign done       = (r_state == S_RELEASE);
  assign timeout    = r_timeout;
  assign result_h   = r_result_h;
  assign result_l   = r_result_l;

endmodule

// File: tb/tb_facto_master.sv
// Self-checking bench for facto_master: behavioural FactoCore + RAM on the bus, table-driven and random jobs.
// Expected results come from an arithmetic factorial model and the documented cycle budget.
// Grant is held high except for a deliberate stall during the operand write.
module tb_facto_master;

  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] operand;
  logic [7:0]  ram_idx;
  logic        interrupt;
  logic        busy, done, timeout;
  logic [63:0] result_h, result_l;

  facto_master_if bus_if ();

  facto_master dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_if.master),
    .start(start), .operand(operand), .ram_idx(ram_idx), .interrupt(interrupt),
    .busy(busy), .done(done), .timeout(timeout),
    .result_h(result_h), .result_l(result_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] fact128(input logic [63:0] n);
    logic [127:0] p;
    p = 128'd1;
    for (int k = 2; k <= int'(n); k++) p = p * 128'(k);
    return p;
  endfunction

  // ---------------- behavioural core + RAM ----------------
  logic [63:0] ram [256];
  logic [63:0] c_opnd, c_hi, c_lo;
  int          int_cnt;
  bit          int_armed;
  int          cfg_d;
  bit          cfg_noint;
  int          done_cnt;
  int          ram_wr_cnt;
  logic [63:0] clr_q [$];

  initial begin
    interrupt = 1'b0; int_armed = 1'b0; int_cnt = 0; done_cnt = 0; ram_wr_cnt = 0;
    c_opnd = '0; c_hi = '0; c_lo = '0; bus_if.m_din = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
  end

  always @(negedge clk) begin
    logic [127:0] f;
    if (done) done_cnt <= done_cnt + 1;
    if (int_armed) begin
      if (int_cnt <= 1) begin interrupt <= 1'b1; int_armed <= 1'b0; end
      else int_cnt <= int_cnt - 1;
    end
    if (bus_if.m_req && bus_if.m_grant) begin
      if (bus_if.m_wr) begin
        if (bus_if.m_addr < 16'h0800) begin
          ram[bus_if.m_addr[10:3]] <= bus_if.m_dout;
          ram_wr_cnt <= ram_wr_cnt + 1;
        end else if (bus_if.m_addr == 16'h7018) begin
          c_opnd <= bus_if.m_dout;
        end else if (bus_if.m_addr == 16'h7000 && bus_if.m_dout == 64'd1) begin
          f = fact128(c_opnd);
          c_hi <= f[127:64];
          c_lo <= f[63:0];
          interrupt <= 1'b0;
          int_armed <= 1'b0;
          if (!cfg_noint) begin
            if (cfg_d == 0) interrupt <= 1'b1;
            else begin int_armed <= 1'b1; int_cnt <= cfg_d; end
          end
        end else if (bus_if.m_addr == 16'h7008) begin
          clr_q.push_back(bus_if.m_dout);
          if (bus_if.m_dout == 64'd1) interrupt <= 1'b0;
        end
      end else begin
        if (bus_if.m_addr == 16'h7020)      bus_if.m_din <= c_hi;
        else if (bus_if.m_addr == 16'h7028) bus_if.m_din <= c_lo;
        else                                bus_if.m_din <= 64'd0;
      end
    end
  end

  // ---------------- job runner ----------------
  typedef struct {
    logic [63:0] op;
    logic [7:0]  idx;
    int          d;
    bit          noint;
    bit          stall;
    bit          restart;
    logic [63:0] exp_h;
    logic [63:0] exp_l;
  } vec_t;

  task automatic run_job(input vec_t v, input string tag);
    int cyc, exp_lat, stall_left, done0, wr0;
    bit stalled;
    logic [7:0] idx_l;
    idx_l = v.idx + 8'd1;
    clr_q.delete();
    ram[v.idx] = 64'hDEAD_BEEF_0000_0001;
    ram[idx_l] = 64'hDEAD_BEEF_0000_0002;
    done0 = done_cnt; wr0 = ram_wr_cnt;
    cfg_d = v.d; cfg_noint = v.noint;
    exp_lat = v.noint ? (4 + TO + 3) : (13 + ((v.d == 0) ? 1 : v.d) + (v.stall ? 5 : 0));
    operand = v.op; ram_idx = v.idx; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, 128'(busy), 128'd1);
    check({tag, "_timeout_clr"}, 128'(timeout), 128'd0);
    check({tag, "_req_on"}, 128'(bus_if.m_req), 128'd1);
    cyc = 1; stall_left = 0; stalled = 0;
    while (!done && cyc < 6000) begin
      if (stall_left > 0) begin
        check({tag, "_stall_hold"}, {47'd0, bus_if.m_wr, bus_if.m_addr, bus_if.m_dout},
              {47'd0, 1'b1, 16'h7018, v.op});
        stall_left--;
        if (stall_left == 0) bus_if.m_grant = 1'b1;
      end else if (v.stall && !stalled && bus_if.m_wr && bus_if.m_addr == 16'h7018) begin
        bus_if.m_grant = 1'b0; stall_left = 5; stalled = 1;
      end
      if (v.restart) begin
        if (cyc == 7) begin start = 1'b1; operand = 64'd99; end
        else start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; bus_if.m_grant = 1'b1;
    check({tag, "_done_seen"}, 128'(done), 128'd1);
    check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    @(posedge clk); #1;
    check({tag, "_busy_off"}, 128'(busy), 128'd0);
    check({tag, "_done_pulse1"}, 128'(done), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_count"}, 128'(done_cnt - done0), 128'd1);
    check({tag, "_result"}, {result_h, result_l}, {v.exp_h, v.exp_l});
    check({tag, "_timeout"}, 128'(timeout), 128'(v.noint));
    if (v.noint) begin
      check({tag, "_no_ram_wr"}, 128'(ram_wr_cnt - wr0), 128'd0);
    end else begin
      check({tag, "_ram_hi"}, 128'(ram[v.idx]), 128'(v.exp_h));
      check({tag, "_ram_lo"}, 128'(ram[idx_l]), 128'(v.exp_l));
    end
    check({tag, "_clr_n"}, 128'(clr_q.size()), 128'd2);
    check({tag, "_clr_seq"}, (clr_q.size() >= 2) ? {clr_q[0], clr_q[1]} : '1, {64'd1, 64'd0});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t tbl [7];
    vec_t rv;
    logic [127:0] f;
    int wcyc;

    tbl[0] = '{64'd5,  8'h02, 10, 1'b0, 1'b0, 1'b0, 64'd0, 64'd120};
    tbl[1] = '{64'd20, 8'hFF, 10, 1'b0, 1'b0, 1'b0, 64'd0, 64'd2432902008176640000};
    tbl[2] = '{64'd7,  8'h10, 10, 1'b0, 1'b1, 1'b0, 64'd0, 64'd5040};
    tbl[3] = '{64'd3,  8'h20, 0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd5040};
    tbl[4] = '{64'd6,  8'h30, 5,  1'b0, 1'b0, 1'b1, 64'd0, 64'd720};
    tbl[5] = '{64'd0,  8'h40, 0,  1'b0, 1'b0, 1'b0, 64'd0, 64'd1};
    tbl[6] = '{64'd21, 8'h50, 1,  1'b0, 1'b0, 1'b0, 64'd2, 64'd14197454024290336768};

    reset_n = 1'b0; start = 1'b0; operand = '0; ram_idx = '0;
    bus_if.m_grant = 1'b1; cfg_d = 0; cfg_noint = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {122'd0, bus_if.m_req, bus_if.m_wr, busy, done, timeout, 1'b0}, 128'd0);
    check("rst_addr_dout", {48'd0, bus_if.m_addr, bus_if.m_dout}, 128'd0);
    check("rst_results", {result_h, result_l}, 128'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.op = 64'($urandom_range(34, 0));
      rv.idx = 8'($urandom_range(255, 0));
      rv.d = int'($urandom_range(20, 0));
      rv.noint = 1'b0; rv.stall = 1'b0; rv.restart = 1'b0;
      f = fact128(rv.op);
      rv.exp_h = f[127:64]; rv.exp_l = f[63:0];
      run_job(rv, $sformatf("rnd%0d", i));
    end

    // Reset asserted while the low result word is being read.
    cfg_d = 4; cfg_noint = 0;
    operand = 64'd9; ram_idx = 8'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wcyc = 0;
    while (!(bus_if.m_req && !bus_if.m_wr && bus_if.m_addr == 16'h7028) && wcyc < 200) begin
      @(posedge clk); #1;
      wcyc++;
    end
    check("mid_rst_reached_resl", 128'(wcyc < 200), 128'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bus", {bus_if.m_req, bus_if.m_wr, bus_if.m_addr, bus_if.m_dout}, 128'd0);
    check("mid_rst_status", {125'd0, busy, done, timeout}, 128'd0);
    check("mid_rst_results", {result_h, result_l}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rv = '{64'd10, 8'h70, 3, 1'b0, 1'b0, 1'b0, 64'd0, 64'd3628800};
    run_job(rv, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
